ofifo: RTL

Output FIFO between the MAC array and the SFU stage. The MAC array columns finish partial sums at different cycles, so each column has its own FIFO. The block presents a full row of `col` partial sums, aligned together, to the downstream SFU accumulate path. A row is released only when every column holds at least one entry.

---
 rtl/ofifo.sv | 104 ++++++++++
 1 files changed

// File: rtl/ofifo.sv
// ofifo: per-column output FIFO between the MAC array and the SFU stage.
// Each MAC column pushes partial sums into its own circular buffer; a full
// row (one entry from every column) is released in lock-step on rd.
module ofifo #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [col*psum_bw-1:0]   in,
  input  logic [col-1:0]           wr,
  input  logic                     rd,
  output logic [col*psum_bw-1:0]   out,
  output logic                     o_valid,
  output logic                     o_full,
  output logic                     o_ready,
  output logic                     o_overflow
);

  localparam int AW = $clog2(depth);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Column storage and pointers. Pointers carry an extra wrap bit so that
  // full and empty are distinguishable without a separate count.
  logic [psum_bw-1:0] r_mem [col][depth];
  logic [AW:0]        r_wptr [col];
  // All columns pop together, so a single shared read pointer suffices and
  // the columns can never drift out of step.
  logic [AW:0]        r_rptr;
  logic               r_overflow;

  logic [col-1:0]     w_empty;
  logic [col-1:0]     w_full;
  logic [col-1:0]     w_wr_en;
  logic               w_rd_en;

  // Per-column status from registered pointers only.
  always_comb begin
    for (int c = 0; c < col; c++) begin
      w_empty[c] = (r_wptr[c] == r_rptr);
      w_full[c]  = (r_wptr[c][AW-1:0] == r_rptr[AW-1:0]) &&
                   (r_wptr[c][AW] != r_rptr[AW]);
    end
  end

  // Accepted writes and reads, judged on pre-edge state.
  assign w_wr_en = wr & ~w_full;
  assign w_rd_en = rd & o_valid;

  assign o_valid    = ~|w_empty;
  assign o_full     = |w_full;
  assign o_ready    = ~o_full;
  assign o_overflow = r_overflow;

  // Head row on out when a full row is present, zeros otherwise.
  always_comb begin
    // NOTE: default assignment first so no path leaves out unassigned,
    // which would otherwise infer a latch.
    out = '0;
    if (o_valid) begin
      for (int c = 0; c < col; c++) begin
        out[c*psum_bw +: psum_bw] = r_mem[c][r_rptr[AW-1:0]];
      end
    end
  end

  // Pointer and sticky overflow update; reset overrides rd and wr.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge
    // values, which is what makes same-edge read and write independent.
    if (reset) begin
      r_rptr     <= '0;
      r_overflow <= 1'b0;
      for (int c = 0; c < col; c++) begin
        r_wptr[c] <= '0;
      end
    end else begin
      if (w_rd_en) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      for (int c = 0; c < col; c++) begin
        if (w_wr_en[c]) begin
          r_wptr[c] <= r_wptr[c] + PTR_ONE;
        end
      end
      if (|(wr & w_full)) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Storage write for accepted column writes.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; contents behind the pointers
    // are never observed, and leaving it unreset lets it map to RAM.
    for (int c = 0; c < col; c++) begin
      if (w_wr_en[c]) begin
        r_mem[c][r_wptr[c][AW-1:0]] <= in[c*psum_bw +: psum_bw];
      end
    end
  end

endmodule
